// File: rtl/lsu_ext.sv
// MEM-stage load/store unit: checks size/alignment, drives a req/ack data bus,
// and returns extended load data or an address-error exception over valid/ready.

module lsu_ext_lane #(
  parameter int DATA_W = 32,
  parameter int LANE   = 0
) (
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  logic [1:0]                  size,
  input  logic [DATA_W-1:0]           wdata,
  output logic                        be,
  output logic [7:0]                  wbyte
);
  localparam int BYTES = DATA_W/8;
  localparam int OFF_W = $clog2(BYTES);
  localparam logic [4:0] L = 5'(LANE);

  logic [4:0]            len, lo;
  logic [OFF_W-1:0]      idx;
  logic [BYTES-1:0][7:0] wb;

  // Lane picks the low 2^size store bytes modulo the access width (replication).
  always_comb begin
    len   = 5'd1 << size;
    lo    = 5'(off);
    be    = (L >= lo) && (L < lo + len);
    idx   = OFF_W'(L & (len - 5'd1));
    wb    = wdata;
    wbyte = wb[idx];
  end
endmodule

module lsu_ext #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_store,
  input  logic [1:0]          in_size,
  input  logic                in_sign,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_rdata,
  output logic                out_exc,
  output logic [4:0]          out_exccode
);
  localparam int BYTES = DATA_W/8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state;

  logic                  st_q, sign_q, flushed;
  logic [1:0]            size_q;
  logic [OFF_W-1:0]      off_q;
  logic [BYTES-1:0]      be_w;
  logic [BYTES-1:0][7:0] wd_w;
  logic                  illegal, misal;
  logic [6:0]            nb;
  logic [DATA_W-1:0]     sh, mask, ext;

  assign in_ready = (state == IDLE);

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    lsu_ext_lane #(.DATA_W(DATA_W), .LANE(g)) u_lane (
      .off(in_addr[OFF_W-1:0]), .size(in_size), .wdata(in_wdata),
      .be(be_w[g]), .wbyte(wd_w[g])
    );
  end

  always_comb begin
    illegal = (in_size == 2'd3) && (DATA_W != 64);
    case (in_size)
      2'd0:    misal = 1'b0;
      2'd1:    misal = in_addr[0];
      2'd2:    misal = |in_addr[1:0];
      default: misal = |in_addr[2:0];
    endcase
  end

  // Field MSB is the top set bit of mask; that bit of sh drives sign extension.
  always_comb begin
    sh   = mem_rdata >> {off_q, 3'b000};
    nb   = 7'd8 << size_q;
    mask = (nb >= 7'(DATA_W)) ? '1 : ~({DATA_W{1'b1}} << nb);
    ext  = (sign_q && |(sh & mask & ~(mask >> 1))) ? (sh | ~mask) : (sh & mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      out_valid   <= 1'b0;
      out_rdata   <= '0;
      out_exc     <= 1'b0;
      out_exccode <= '0;
      st_q        <= 1'b0;
      sign_q      <= 1'b0;
      flushed     <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st_q    <= in_store;
          sign_q  <= in_sign;
          size_q  <= in_size;
          off_q   <= in_addr[OFF_W-1:0];
          flushed <= 1'b0;
          if (illegal || misal) begin
            out_valid   <= 1'b1;
            out_exc     <= 1'b1;
            out_rdata   <= '0;
            out_exccode <= illegal ? 5'd10 : (in_store ? 5'd5 : 5'd4);
            state       <= RESP;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= in_store;
            mem_addr  <= in_addr & ~ADDR_W'(BYTES-1);
            mem_be    <= in_store ? be_w : '1;
            mem_wdata <= in_store ? DATA_W'(wd_w) : '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (flush) flushed <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (flush || flushed) begin
              state <= IDLE;
            end else begin
              out_valid   <= 1'b1;
              out_exc     <= 1'b0;
              out_exccode <= '0;
              out_rdata   <= st_q ? '0 : ext;
              state       <= RESP;
            end
          end
        end
        RESP: if (flush || out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ext.sv
// Scoreboarded bench for lsu_ext: one 32-bit and one 64-bit instance sharing stimulus,
// only the selected instance ever sees in_valid.

module tb_lsu_ext;
  logic clk = 1'b0;
  logic reset;
  logic a_iv, b_iv, st, sg, fl, ack, ordy, sel;
  logic [1:0]  sz;
  logic [63:0] addr, wd, rd;

  logic        a_ir, a_req, a_we, a_ov, a_exc;
  logic [31:0] a_maddr, a_wd, a_ord;
  logic [3:0]  a_be;
  logic [4:0]  a_code;
  logic        b_ir, b_req, b_we, b_ov, b_exc;
  logic [31:0] b_maddr;
  logic [63:0] b_wd, b_ord;
  logic [7:0]  b_be;
  logic [4:0]  b_code;

  logic        o_ir, o_req, o_we, o_ov, o_exc;
  logic [63:0] o_maddr, o_be, o_wd, o_ord;
  logic [4:0]  o_code;

  typedef struct packed {logic [63:0] rd; logic exc; logic [4:0] code;} exp_t;
  exp_t sbq[$];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  lsu_ext #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .in_store(st),
    .in_size(sz), .in_sign(sg), .in_addr(addr[31:0]), .in_wdata(wd[31:0]), .flush(fl),
    .mem_req(a_req), .mem_we(a_we), .mem_addr(a_maddr), .mem_be(a_be), .mem_wdata(a_wd),
    .mem_ack(ack), .mem_rdata(rd[31:0]), .out_valid(a_ov), .out_ready(ordy),
    .out_rdata(a_ord), .out_exc(a_exc), .out_exccode(a_code)
  );

  lsu_ext #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir), .in_store(st),
    .in_size(sz), .in_sign(sg), .in_addr(addr[31:0]), .in_wdata(wd), .flush(fl),
    .mem_req(b_req), .mem_we(b_we), .mem_addr(b_maddr), .mem_be(b_be), .mem_wdata(b_wd),
    .mem_ack(ack), .mem_rdata(rd), .out_valid(b_ov), .out_ready(ordy),
    .out_rdata(b_ord), .out_exc(b_exc), .out_exccode(b_code)
  );

  assign o_ir    = sel ? b_ir  : a_ir;
  assign o_req   = sel ? b_req : a_req;
  assign o_we    = sel ? b_we  : a_we;
  assign o_ov    = sel ? b_ov  : a_ov;
  assign o_exc   = sel ? b_exc : a_exc;
  assign o_code  = sel ? b_code : a_code;
  assign o_maddr = sel ? 64'(b_maddr) : 64'(a_maddr);
  assign o_be    = sel ? 64'(b_be)    : 64'(a_be);
  assign o_wd    = sel ? b_wd         : 64'(a_wd);
  assign o_ord   = sel ? b_ord        : 64'(a_ord);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    exp_t e;
    logic [63:0] held;
    while (!o_ov && k < 20) begin @(negedge clk); k++; end
    chk({tag, ".ov"}, 64'(o_ov), 64'd1);
    held = o_ord;
    @(negedge clk);
    chk({tag, ".hold"}, o_ord, held);
    if (sbq.size() == 0) chk({tag, ".sbempty"}, 64'd0, 64'd1);
    else begin
      e = sbq.pop_front();
      chk({tag, ".rdata"}, o_ord, e.rd);
      chk({tag, ".exc"}, 64'(o_exc), 64'(e.exc));
      chk({tag, ".code"}, 64'(o_code), 64'(e.code));
    end
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk({tag, ".ovdrop"}, 64'(o_ov), 64'd0);
    chk({tag, ".irdy"}, 64'(o_ir), 64'd1);
  endtask

  task automatic run(input string tag, input bit w64, input bit s, input logic [1:0] z,
                     input bit g, input logic [63:0] a, input logic [63:0] w,
                     input logic [63:0] r, input int waits, input bit f,
                     input logic [63:0] ebe, input logic [63:0] ewd,
                     input logic [63:0] erd, input logic [4:0] code);
    exp_t e;
    sel = w64; st = s; sz = z; sg = g; addr = a; wd = w;
    if (w64) b_iv = 1'b1; else a_iv = 1'b1;
    e.rd = erd; e.exc = (code != 0); e.code = code;
    if (!f) sbq.push_back(e);
    @(negedge clk);
    a_iv = 1'b0; b_iv = 1'b0;
    if (code != 0) begin
      chk({tag, ".noreq"}, 64'(o_req), 64'd0);
      chk({tag, ".lat1"}, 64'(o_ov), 64'd1);
    end else begin
      chk({tag, ".req"}, 64'(o_req), 64'd1);
      chk({tag, ".we"}, 64'(o_we), 64'(s));
      chk({tag, ".addr"}, o_maddr, a & ~(w64 ? 64'd7 : 64'd3));
      chk({tag, ".be"}, o_be, ebe);
      if (s) chk({tag, ".wdata"}, o_wd, ewd);
      if (f) fl = 1'b1;
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        fl = 1'b0;
        chk({tag, ".reqhold"}, 64'(o_req), 64'd1);
      end
      ack = 1'b1; rd = r;
      @(negedge clk);
      ack = 1'b0; fl = 1'b0;
      chk({tag, ".reqdrop"}, 64'(o_req), 64'd0);
      if (f) begin
        chk({tag, ".noov"}, 64'(o_ov), 64'd0);
        chk({tag, ".irdy"}, 64'(o_ir), 64'd1);
        return;
      end
      chk({tag, ".lat"}, 64'(o_ov), 64'd1);
    end
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no summary after %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; a_iv = 0; b_iv = 0; st = 0; sg = 0; fl = 0; ack = 0; ordy = 0; sel = 0;
    sz = 0; addr = 0; wd = 0; rd = 0;
    repeat (2) @(negedge clk);
    chk("rst.irdy", 64'(o_ir), 64'd1);
    chk("rst.req", 64'(o_req), 64'd0);
    chk("rst.be", o_be, 64'd0);
    chk("rst.ov", 64'(o_ov), 64'd0);
    chk("rst.code", 64'(o_code), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run("wld",   0, 0, 2'd0 + 2'd2, 1, 64'h1000, 0, 64'h8899AABB, 0, 0, 64'hF, 0, 64'h8899AABB, 0);
    run("bld_s", 0, 0, 2'd0, 1, 64'h1002, 0, 64'h11F23344, 0, 0, 64'hF, 0, 64'hFFFFFFF2, 0);
    run("bld_u", 0, 0, 2'd0, 0, 64'h1002, 0, 64'h11F23344, 1, 0, 64'hF, 0, 64'h000000F2, 0);
    run("hld",   0, 0, 2'd1, 1, 64'h1002, 0, 64'h80015555, 0, 0, 64'hF, 0, 64'hFFFF8001, 0);
    run("hst",   0, 1, 2'd1, 0, 64'h2002, 64'hBEEF, 0, 3, 0, 64'hC, 64'hBEEFBEEF, 0, 0);
    run("adel",  0, 0, 2'd2, 1, 64'h1002, 0, 0, 0, 0, 0, 0, 0, 5'd4);
    run("ades",  0, 1, 2'd1, 0, 64'h2001, 64'h1234, 0, 0, 0, 0, 0, 0, 5'd5);
    run("ri",    0, 0, 2'd3, 0, 64'h1001, 0, 0, 0, 0, 0, 0, 0, 5'd10);
    run("flush", 0, 0, 2'd2, 0, 64'h1000, 0, 64'hDEAD, 2, 1, 64'hF, 0, 0, 0);
    run("dld",   1, 0, 2'd3, 0, 64'h2008, 0, 64'h0123456789ABCDEF, 0, 0, 64'hFF, 0,
        64'h0123456789ABCDEF, 0);
    run("b7",    1, 0, 2'd0, 1, 64'h200F, 0, 64'h8000000000000000, 1, 0, 64'hFF, 0,
        64'hFFFFFFFFFFFFFF80, 0);
    run("wld64", 1, 0, 2'd2, 1, 64'h2004, 0, 64'h89ABCDEF00000000, 0, 0, 64'hFF, 0,
        64'hFFFFFFFF89ABCDEF, 0);
    run("wst64", 1, 1, 2'd2, 0, 64'h2004, 64'h12345678, 0, 0, 0, 64'hF0,
        64'h1234567812345678, 0, 0);

    // Flush while an exception result is waiting.
    sel = 0; st = 0; sz = 2'd2; addr = 64'h1002; a_iv = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    chk("rflush.ov", 64'(o_ov), 64'd1);
    fl = 1'b1;
    @(negedge clk);
    fl = 1'b0;
    chk("rflush.drop", 64'(o_ov), 64'd0);
    chk("rflush.irdy", 64'(o_ir), 64'd1);

    // Asynchronous reset mid-transaction.
    sel = 0; st = 0; sz = 2'd2; addr = 64'h3000; a_iv = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    chk("areset.req", 64'(o_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("areset.drop", 64'(o_req), 64'd0);
    chk("areset.irdy", 64'(o_ir), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("areset.idle", 64'(o_req), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
